// File: rtl/sqrt_iter_if.sv
// Operand/result bundle for the FP16 square-root iteration stage.
// slave = the sqrt stage, master = whoever feeds it and consumes its result.
interface sqrt_iter_if #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
);
  logic              u_valid;
  logic              in_ready;
  logic              sign_in;
  logic [EXP_W-1:0]  exp_in;
  logic [MANT_W-1:0] mant_in;
  logic              is_nan_in;
  logic              is_pinf_in;
  logic              is_ninf_in;
  logic              is_zero_in;

  logic              it_valid;
  logic              sign_out;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] mant_out;
  logic              is_nan_out;
  logic              is_pinf_out;
  logic              is_ninf_out;
  logic              result_out;

  modport slave (
    input  u_valid, sign_in, exp_in, mant_in,
           is_nan_in, is_pinf_in, is_ninf_in, is_zero_in,
    output in_ready, it_valid, sign_out, exp_out, mant_out,
           is_nan_out, is_pinf_out, is_ninf_out, result_out
  );

  modport master (
    output u_valid, sign_in, exp_in, mant_in,
           is_nan_in, is_pinf_in, is_ninf_in, is_zero_in,
    input  in_ready, it_valid, sign_out, exp_out, mant_out,
           is_nan_out, is_pinf_out, is_ninf_out, result_out
  );
endinterface

// File: rtl/sqrt_iter.sv
// FP16 square-root iteration stage: restoring digit-by-digit root, one bit per cycle.
// Define SQRT_ROUND_NEAREST_EN to compute a guard bit and round half-up.
module sqrt_iter #(
  parameter int MANT_W = 11,
  parameter int EXP_W  = 7
) (
  input logic        clk,
  input logic        rst_n,
  input logic        enable,
  sqrt_iter_if.slave bus
);

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int STEPS = MANT_W + 1;
`else
  localparam int STEPS = MANT_W;
`endif
  localparam int RAD_W  = 2 * STEPS;
  localparam int ROOT_W = STEPS;
  localparam int REM_W  = STEPS + 2;
  localparam int SH_W   = REM_W + 2;
  localparam logic [3:0]       LAST     = 4'(STEPS - 1);
  localparam logic [EXP_W-1:0] EXP_ZERO = EXP_W'(-15);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [RAD_W-1:0]  rad_q;
  logic [REM_W-1:0]  rem_q;
  logic [ROOT_W-1:0] root_q;
  logic [3:0]        cnt_q;

  logic              sign_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic              nan_q;
  logic              pinf_q;
  logic              ninf_q;
  logic              res_q;

  logic                    accept;
  logic                    is_special;
  logic [RAD_W-1:0]        rad_init;
  logic signed [EXP_W-1:0] exp_half;
  logic [SH_W-1:0]         rem_sh;
  logic [SH_W-1:0]         trial;
  logic                    step_ge;
  logic [REM_W-1:0]        rem_nx;
  logic [ROOT_W-1:0]       root_nx;
`ifdef SQRT_ROUND_NEAREST_EN
  logic [MANT_W:0]         rounded;
`endif

  assign accept     = enable && bus.u_valid && (state_q == IDLE);
  assign is_special = bus.is_nan_in || bus.is_pinf_in || bus.is_ninf_in ||
                      bus.is_zero_in || bus.sign_in;

  // Odd exponents fold one factor of two into the radicand so the halved exponent is exact.
  assign exp_half = $signed(bus.exp_in) >>> 1;

  always_comb begin
    rad_init = {bus.mant_in, {(RAD_W-MANT_W){1'b0}}};
    if (!bus.exp_in[0]) begin
      rad_init = rad_init >> 1;
    end
  end

  always_comb begin
    rem_sh  = {rem_q, rad_q[RAD_W-1 -: 2]};
    trial   = SH_W'({root_q, 2'b01});
    step_ge = (rem_sh >= trial);
    rem_nx  = step_ge ? REM_W'(rem_sh - trial) : REM_W'(rem_sh);
    root_nx = {root_q[ROOT_W-2:0], step_ge};
  end

`ifdef SQRT_ROUND_NEAREST_EN
  assign rounded = {1'b0, root_nx[ROOT_W-1:1]} + {{MANT_W{1'b0}}, root_nx[0]};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (bus.u_valid) begin
            state_d = is_special ? DONE : CALC;
          end
        end
        CALC: begin
          if (cnt_q == LAST) begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      mant_q <= '0;
      nan_q  <= 1'b0;
      pinf_q <= 1'b0;
      ninf_q <= 1'b0;
      res_q  <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        rad_q  <= rad_init;
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= '0;
        sign_q <= 1'b0;
        exp_q  <= exp_half;
        mant_q <= '0;
        nan_q  <= 1'b0;
        pinf_q <= 1'b0;
        ninf_q <= 1'b0;
        res_q  <= 1'b0;
        // Signed zero must win over the negative-operand NaN rule.
        if (bus.is_nan_in) begin
          nan_q <= 1'b1;
          exp_q <= '0;
        end else if (bus.is_zero_in) begin
          sign_q <= bus.sign_in;
          exp_q  <= EXP_ZERO;
        end else if (bus.sign_in || bus.is_ninf_in) begin
          nan_q <= 1'b1;
          exp_q <= '0;
        end else if (bus.is_pinf_in) begin
          pinf_q <= 1'b1;
          exp_q  <= '0;
        end
      end else if (state_q == CALC) begin
        rad_q  <= rad_q << 2;
        rem_q  <= rem_nx;
        root_q <= root_nx;
        cnt_q  <= cnt_q + 4'd1;
        if (cnt_q == LAST) begin
`ifdef SQRT_ROUND_NEAREST_EN
          if (rounded[MANT_W]) begin
            mant_q <= {1'b1, {(MANT_W-1){1'b0}}};
            exp_q  <= exp_q + EXP_W'(1);
          end else begin
            mant_q <= rounded[MANT_W-1:0];
          end
          res_q <= root_nx[0] | (rem_nx != '0);
`else
          mant_q <= root_nx;
          res_q  <= (rem_nx != '0);
`endif
        end
      end
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.it_valid    = (state_q == DONE);
  assign bus.sign_out    = sign_q;
  assign bus.exp_out     = exp_q;
  assign bus.mant_out    = mant_q;
  assign bus.is_nan_out  = nan_q;
  assign bus.is_pinf_out = pinf_q;
  assign bus.is_ninf_out = ninf_q;
  assign bus.result_out  = res_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: vector table plus stall, reset-abort and back-to-back sequences.
// Expected values follow SQRT_ROUND_NEAREST_EN when it is defined.
module tb_sqrt_iter;

`ifdef SQRT_ROUND_NEAREST_EN
  localparam int LAT_N = 13;
  localparam logic [10:0] M3 = 11'h6EE;
`else
  localparam int LAT_N = 12;
  localparam logic [10:0] M3 = 11'h6ED;
`endif

  typedef struct {
    string       name;
    logic        sign;
    logic [6:0]  exp;
    logic [10:0] mant;
    logic [3:0]  cls;
    logic        e_sign;
    logic [6:0]  e_exp;
    logic [10:0] e_mant;
    logic [2:0]  e_flags;
    logic        chk_em;
    int          e_lat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  int checks = 0;
  int fails  = 0;
  vec_t vecs[15];

  sqrt_iter_if bus();

  sqrt_iter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string n, logic s, logic [6:0] e, logic [10:0] m, logic [3:0] cls,
                              logic es, logic [6:0] ee, logic [10:0] em, logic [2:0] ef,
                              logic chk, int lat);
    vec_t v;
    v.name = n; v.sign = s; v.exp = e; v.mant = m; v.cls = cls;
    v.e_sign = es; v.e_exp = ee; v.e_mant = em; v.e_flags = ef; v.chk_em = chk; v.e_lat = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic driveOperand(input vec_t v);
    bus.sign_in    = v.sign;
    bus.exp_in     = v.exp;
    bus.mant_in    = v.mant;
    bus.is_nan_in  = v.cls[3];
    bus.is_pinf_in = v.cls[2];
    bus.is_ninf_in = v.cls[1];
    bus.is_zero_in = v.cls[0];
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    @(negedge clk);
    checkOutput({v.name, " in_ready"}, int'(bus.in_ready), 1);
    driveOperand(v);
    bus.u_valid = 1'b1;
    @(posedge clk);
    #1 bus.u_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.it_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic verifyResult(input vec_t v, input int lat);
    checkOutput({v.name, " latency"}, lat, v.e_lat);
    if (v.chk_em) begin
      checkOutput({v.name, " sign"}, int'(bus.sign_out), int'(v.e_sign));
      checkOutput({v.name, " exp"},  int'(bus.exp_out),  int'(v.e_exp));
      checkOutput({v.name, " mant"}, int'(bus.mant_out), int'(v.e_mant));
    end
    checkOutput({v.name, " nan"},    int'(bus.is_nan_out),  int'(v.e_flags[2]));
    checkOutput({v.name, " pinf"},   int'(bus.is_pinf_out), int'(v.e_flags[1]));
    checkOutput({v.name, " ninf"},   int'(bus.is_ninf_out), 0);
    checkOutput({v.name, " result"}, int'(bus.result_out),  int'(v.e_flags[0]));
    @(negedge clk);
    checkOutput({v.name, " pulse_end"}, int'(bus.it_valid), 0);
  endtask

  initial begin
    int lat;
    int edges;
    int pulses;
    int accepts;
    int acc2_edge;
    int pulse_edge[2];
    logic seen;

    vecs[0]  = mk("sqrt_4",    0, 7'h02, 11'h400, 4'b0000, 0, 7'h01, 11'h400, 3'b000, 1, LAT_N);
    vecs[1]  = mk("sqrt_2",    0, 7'h01, 11'h400, 4'b0000, 0, 7'h00, 11'h5A8, 3'b001, 1, LAT_N);
    vecs[2]  = mk("sqrt_1",    0, 7'h00, 11'h400, 4'b0000, 0, 7'h00, 11'h400, 3'b000, 1, LAT_N);
    vecs[3]  = mk("sqrt_9",    0, 7'h03, 11'h480, 4'b0000, 0, 7'h01, 11'h600, 3'b000, 1, LAT_N);
    vecs[4]  = mk("sqrt_qtr",  0, 7'h7E, 11'h400, 4'b0000, 0, 7'h7F, 11'h400, 3'b000, 1, LAT_N);
    vecs[5]  = mk("sqrt_half", 0, 7'h7F, 11'h400, 4'b0000, 0, 7'h7F, 11'h5A8, 3'b001, 1, LAT_N);
    vecs[6]  = mk("sqrt_3",    0, 7'h01, 11'h600, 4'b0000, 0, 7'h00, M3,      3'b001, 1, LAT_N);
    vecs[7]  = mk("sqrt_max",  0, 7'h0F, 11'h7FF, 4'b0000, 0, 7'h07, 11'h7FF, 3'b001, 1, LAT_N);
    vecs[8]  = mk("sqrt_min",  0, 7'h68, 11'h400, 4'b0000, 0, 7'h74, 11'h400, 3'b000, 1, LAT_N);
    vecs[9]  = mk("pos_zero",  0, 7'h00, 11'h000, 4'b0001, 0, 7'h71, 11'h000, 3'b000, 1, 1);
    vecs[10] = mk("neg_zero",  1, 7'h00, 11'h000, 4'b0001, 1, 7'h71, 11'h000, 3'b000, 1, 1);
    vecs[11] = mk("neg_four",  1, 7'h02, 11'h400, 4'b0000, 0, 7'h00, 11'h000, 3'b100, 0, 1);
    vecs[12] = mk("nan",       0, 7'h10, 11'h600, 4'b1000, 0, 7'h00, 11'h000, 3'b100, 0, 1);
    vecs[13] = mk("pos_inf",   0, 7'h10, 11'h400, 4'b0100, 0, 7'h00, 11'h000, 3'b010, 0, 1);
    vecs[14] = mk("neg_inf",   1, 7'h10, 11'h400, 4'b0010, 0, 7'h00, 11'h000, 3'b100, 0, 1);

    bus.u_valid = 1'b0;
    driveOperand(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", int'(bus.in_ready),   1);
    checkOutput("reset it_valid", int'(bus.it_valid),   0);
    checkOutput("reset exp",      int'(bus.exp_out),    0);
    checkOutput("reset mant",     int'(bus.mant_out),   0);
    checkOutput("reset flags",    int'({bus.sign_out, bus.is_nan_out, bus.is_pinf_out,
                                        bus.is_ninf_out, bus.result_out}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], lat);
      verifyResult(vecs[i], lat);
    end

    // Five frozen edges mid-CALC, then two more frozen edges while DONE.
    @(negedge clk);
    driveOperand(vecs[1]);
    bus.u_valid = 1'b1;
    @(posedge clk);
    #1 bus.u_valid = 1'b0;
    edges = 1;
    @(negedge clk);
    while (!bus.it_valid && edges < 100) begin
      enable = (edges >= 3 && edges < 8) ? 1'b0 : 1'b1;
      if (edges == 5) checkOutput("stall in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    enable = 1'b1;
    checkOutput("stall latency", edges, LAT_N + 5);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("stall done hold", int'(bus.it_valid), 1);
    checkOutput("stall done in_ready", int'(bus.in_ready), 0);
    enable = 1'b1;
    checkOutput("stall mant",   int'(bus.mant_out),   int'(vecs[1].e_mant));
    checkOutput("stall result", int'(bus.result_out), 1);
    @(negedge clk);
    checkOutput("stall pulse_end", int'(bus.it_valid), 0);

    // Reset partway through CALC abandons the operation.
    @(negedge clk);
    driveOperand(vecs[1]);
    bus.u_valid = 1'b1;
    @(posedge clk);
    #1 bus.u_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort in_ready", int'(bus.in_ready), 1);
    checkOutput("abort it_valid", int'(bus.it_valid), 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.it_valid) seen = 1'b1;
    end
    checkOutput("abort no_valid", int'(seen), 0);
    applyStimulus(vecs[2], lat);
    verifyResult(vecs[2], lat);

    // u_valid held high across two operands.
    pulses = 0;
    accepts = 0;
    acc2_edge = 0;
    pulse_edge[0] = 0;
    pulse_edge[1] = 0;
    @(negedge clk);
    driveOperand(vecs[0]);
    bus.u_valid = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      seen = bus.in_ready && bus.u_valid;
      @(posedge clk);
      #1;
      if (seen) begin
        accepts++;
        if (accepts == 1) driveOperand(vecs[3]);
        else begin
          bus.u_valid = 1'b0;
          acc2_edge = e;
        end
      end
      @(negedge clk);
      if (bus.it_valid) begin
        if (pulses < 2) begin
          pulse_edge[pulses] = e;
          checkOutput("b2b mant", int'(bus.mant_out),
                      (pulses == 0) ? int'(vecs[0].e_mant) : int'(vecs[3].e_mant));
        end
        pulses++;
      end
    end
    checkOutput("b2b pulses",       pulses,        2);
    checkOutput("b2b first_valid",  pulse_edge[0], LAT_N);
    checkOutput("b2b second_accept", acc2_edge,    LAT_N + 2);
    checkOutput("b2b second_valid", pulse_edge[1], 2 * LAT_N + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sqrt_iter.md
Name: sqrt_iter

Overview:
- Iterative FP16 square-root core stage: takes an unpacked, normalised operand and produces the root mantissa, the halved exponent and the special-case flags.
- Computes one root bit per cycle using a restoring digit-by-digit algorithm.
- Sits directly upstream of the pack stage: drives its it_valid, sign/exp/mant, is_nan/is_pinf/is_ninf and result inputs.
- Fed by the unpack stage through a valid/ready handshake.

Parameters:
- MANT_W, 11: mantissa width including hidden bit; fixed at 11 for FP16.
- EXP_W, 7: signed unbiased exponent width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  global advance; 0 freezes all state
- u_valid  in  1  upstream operand valid
- in_ready  out  1  stage can accept an operand
- sign_in  in  1  operand sign
- exp_in  in  7  signed unbiased exponent; subnormals arrive pre-normalised
- mant_in  in  11  normalised mantissa, bit10 = 1 unless zero
- is_nan_in, is_pinf_in, is_ninf_in, is_zero_in  in  1 each  operand class flags
- it_valid  out  1  result valid to pack stage
- sign_out  out  1  result sign
- exp_out  out  7  signed unbiased result exponent
- mant_out  out  11  root mantissa
- is_nan_out, is_pinf_out, is_ninf_out  out  1 each  result class flags
- result_out  out  1  inexact flag; remainder ≠ 0 after the last iteration

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - All outputs go to 0, except in_ready = 1 and exp_out = 0.
  - Reset in CALC or DONE discards the operation; no it_valid is issued.
- enable=0: state, datapath and outputs hold; it_valid remains at its current value.
- State IDLE:
  - in_ready = 1.
  - Acceptance is u_valid & enable at a clk edge.
  - On acceptance, the class decides the next state:
    - NaN, +inf, -inf, zero, or negative nonzero: go to DONE (special path).
    - Otherwise: go to CALC.
- Operand set-up on acceptance:
  - If exp_in is even: radicand R = mant_in << 10 (22 bits); e_adj = exp_in.
  - If exp_in is odd: R = mant_in << 11; e_adj = exp_in - 1.
  - exp_out = e_adj >>> 1 (arithmetic); result range -12..+7.
  - Clear root and remainder.
- State CALC: one restoring step per enabled cycle, for exactly 11 steps, MSB root bit first.
  - rem = (rem << 2) | next two radicand bits.
  - trial = (root << 2) | 1.
  - If rem ≥ trial: rem -= trial and root = (root << 1) | 1; else root = root << 1.
  - A 4-bit counter counts the steps; after step 11, go to DONE.
  - Root bit10 is always 1 for nonzero input.
- State DONE:
  - it_valid = 1; in_ready = 0.
  - Moves to IDLE at the next edge with enable=1. The pack stage samples on that same edge, so it_valid is seen exactly once per operation.
- Latency (all edges enabled):
  - Normal path: it_valid goes high 12 edges after acceptance.
  - Special path: it_valid goes high 1 edge after acceptance.
- No new operand is accepted in CALC or DONE; upstream holds u_valid.
- Special path outputs:
  - NaN in, or negative nonzero (including -inf): is_nan_out = 1.
  - +inf: is_pinf_out = 1.
  - ±0: sign_out = sign_in, exp_out = -15, mant_out = 0.
  - In all special cases: result_out = 0.
- Normal path: sign_out = 0; mant_out = root[10:0]; result_out = (rem ≠ 0).
- All outputs are registered; no combinational path from inputs to outputs except in_ready (which is state-derived only).

Optional Feature:
- Macro: SQRT_ROUND_NEAREST_EN.
- Defined:
  - CALC runs 12 steps (radicand extended by 2 zero LSBs); latency becomes 13.
  - Root = top 11 bits + guard bit (round half-up).
  - If the increment carries to 2048: mant_out = 1024 and exp_out + 1.
  - result_out = guard | (rem ≠ 0).
- Undefined: truncation as above; 11 steps.

Test Plan:
- 4.0 (exp_in=2, mant_in=0x400, sign=0) → exp_out=1, mant_out=0x400, result_out=0, it_valid 12 cycles after accept.
- 2.0 (exp_in=1, mant_in=0x400) → exp_out=0, mant_out=0x5A8 (1448), result_out=1; same with SQRT_ROUND_NEAREST_EN.
- -0 (is_zero_in=1, sign_in=1) → sign_out=1, exp_out=-15, mant_out=0, it_valid 1 cycle after accept; -4.0 → is_nan_out=1.
- enable held low for 5 cycles mid-CALC → it_valid delayed exactly 5 cycles, result unchanged; in_ready=0 throughout CALC/DONE.
- rst_n=0 at step 6 of CALC → next cycle IDLE, in_ready=1, it_valid never asserted; next operand 1.0 (exp 0, 0x400) → mant_out 0x400, exp_out 0.
- Back-to-back: u_valid held high with two operands → second accepted only on the cycle after DONE, two separate one-cycle it_valid pulses.
